// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit producing HI/LO results.
// Optional MULDIV_UNSIGNED_EN: op[1] selects MULTU/DIVU; otherwise every op is signed.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             signed_op;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [2*WIDTH-1:0] prod;

`ifndef MULDIV_UNSIGNED_EN
  logic unused_op1;
  assign unused_op1 = op[1];
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    wrk_d      = wrk_q;
    mb_d       = mb_q;
    div_d      = div_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sum        = '0;
    shifted    = '0;
    diff       = '0;
    prod       = '0;
`ifdef MULDIV_UNSIGNED_EN
    signed_op  = ~op[1];
`else
    signed_op  = 1'b1;
`endif
    a_neg      = signed_op & a_in[WIDTH-1];
    b_neg      = signed_op & b_in[WIDTH-1];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d      = '0;
          acc_d      = '0;
          wrk_d      = a_neg ? -a_in : a_in;
          mb_d       = b_neg ? -b_in : b_in;
          div_d      = op[0];
          div_zero_d = op[0] && (b_in == '0);
          // Divide: quotient sign from operand XOR, remainder follows dividend.
          neg_lo_d   = a_neg ^ b_neg;
          neg_hi_d   = op[0] ? a_neg : (a_neg ^ b_neg);
          state_d    = op[0] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        sum   = wrk_q[0] ? ({1'b0, acc_q} + {1'b0, mb_q}) : {1'b0, acc_q};
        acc_d = sum[WIDTH:1];
        wrk_d = {sum[0], wrk_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (div_zero_q) begin
          state_d = S_DONE;
        end else begin
          shifted = {acc_q, wrk_q[WIDTH-1]};
          diff    = shifted - {1'b0, mb_q};
          if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = shifted[WIDTH-1:0];
            wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (div_q) begin
          lo_d = neg_lo_q ? -wrk_q : wrk_q;
          hi_d = neg_hi_q ? -acc_q : acc_q;
        end else begin
          prod = {acc_q, wrk_q};
          if (neg_lo_q) prod = -prod;
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  // Iteration datapath needs no reset: it is fully reloaded on every start.
  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    acc_q    <= acc_d;
    wrk_q    <= wrk_d;
    mb_q     <= mb_d;
    div_q    <= div_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
  end

  assign busy     = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
  assign done     = (state_q == S_DONE);
  assign div_zero = div_zero_q;
  assign hi_out   = hi_q;
  assign lo_out   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results queued at issue, checked when done pulses.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in, b_in;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mhi = '0, mlo = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errs = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit sgn;
    longint sa, sb_v;
    logic [63:0] p, q, r;
    sgn = 1'b1;
`ifdef MULDIV_UNSIGNED_EN
    sgn = !o[1];
`endif
    sa   = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb_v = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    e.dz = 1'b0;
    e.lat = 34;
    if (!o[0]) begin
      p = sa * sb_v;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'd0) begin
      e.dz = 1'b1;
      e.lat = 2;
      e.hi = mhi;
      e.lo = mlo;
    end else begin
      q = sa / sb_v;
      r = sa % sb_v;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    e.start_cyc = 0;
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    e = model(o, a, b);
    e.start_cyc = cyc + 1;
    mhi = e.hi;
    mlo = e.lo;
    sb.push_back(e);
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_errs++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    @(negedge clk);
    chk("done_one_cycle", {63'b0, done}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    issue(o, a, b);
    @(negedge clk);
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    wait_done();
  endtask

  // Monitor: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_done: got done with hi=%h lo=%h expected no done", hi_out, lo_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hi_out", {32'b0, hi_out}, {32'b0, e.hi});
        chk("lo_out", {32'b0, lo_out}, {32'b0, e.lo});
        chk("div_zero", {63'b0, div_zero}, {63'b0, e.dz});
        chk("latency", 64'(cyc - e.start_cyc + 1), 64'(e.lat));
        chk("busy_in_done", {63'b0, busy}, 64'd0);
      end
    end
  end

  initial begin
    logic [31:0] specials [6];
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h0000_0001;
    specials[3] = 32'h7FFF_FFFF; specials[4] = 32'h0000_0000; specials[5] = 32'h0000_0002;

    reset = 1'b0; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_div_zero", {63'b0, div_zero}, 64'd0);
    chk("rst_hi", {32'b0, hi_out}, 64'd0);
    chk("rst_lo", {32'b0, lo_out}, 64'd0);
    reset = 1'b1;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2);
    run_op(2'b01, 32'd5, 32'd0);
    run_op(2'b00, 32'd2, 32'd3);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);

    // A start during busy must be dropped without queueing.
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 2'b01; a_in = 32'd100; b_in = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    run_op(2'b10, 32'hFFFF_FFFF, 32'd2);
    run_op(2'b11, 32'hFFFF_FFF0, 32'd3);

    // Reset in the middle of a multiply discards it.
    run_op(2'b00, 32'h1234_5678, 32'h0000_0100);
    issue(2'b00, 32'd1000, 32'd1000);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_hi", {32'b0, hi_out}, 64'd0);
    chk("midrst_lo", {32'b0, lo_out}, 64'd0);
    sb.delete();
    mhi = '0;
    mlo = '0;
    reset = 1'b1;
    repeat (40) @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 1) == 0) b = b >> $urandom_range(0, 31);
      run_op(2'($urandom), a, b);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
